// File: rtl/shift_add_mult_ctrl_16b.sv
// shift_add_mult_ctrl_16b: sequencing and accumulation stage of a 16-bit
// shift-add multiplier. Drives an external shift register holding the
// multiplier (and, as iterations proceed, the low product half), owns the
// multiplicand, the accumulator (high product half), the iteration counter
// and the start/busy/done handshake.
// Optional feature macro: MULT_SIGNED_EN (two's-complement operands).
module shift_add_mult_ctrl_16b #(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           r,
   input  logic           start,
   input  logic [N-1:0]   mcand,
   input  logic [N-1:0]   mplier,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product,
   output logic [N-1:0]   sr_value,
   output logic           sr_load,
   output logic           sr_in,
   input  logic [N-1:0]   sr_q
);

   localparam int unsigned CW = $clog2(N);
   localparam int unsigned PW = 2 * N;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q,   state_d;
   logic [N-1:0]  mc_q,      mc_d;
   logic [N-1:0]  acc_q,     acc_d;
   logic [CW-1:0] cnt_q,     cnt_d;
   logic [PW-1:0] product_q, product_d;
   logic          done_q,    done_d;

   logic [N:0]    sum_c;
   logic [N-1:0]  mcand_op_c;
   logic [N-1:0]  mplier_op_c;
   logic [PW-1:0] result_c;
   logic [PW-1:0] raw_c;

`ifdef MULT_SIGNED_EN
   logic neg_q, neg_d;

   // Magnitude of a two's-complement value; the most negative value maps to itself.
   function automatic logic [N-1:0] mag(input logic [N-1:0] x);
      mag = x[N-1] ? N'(~x + N'(1)) : x;
   endfunction

   // Operands enter the datapath as magnitudes; the sign is reapplied at the end.
   always_comb begin
      mcand_op_c  = mag(mcand);
      mplier_op_c = mag(mplier);
      raw_c       = {acc_q, sr_q};
      result_c    = neg_q ? PW'(~raw_c + PW'(1)) : raw_c;
   end
`else
   // Unsigned operands pass straight through.
   always_comb begin
      mcand_op_c  = mcand;
      mplier_op_c = mplier;
      raw_c       = {acc_q, sr_q};
      result_c    = raw_c;
   end
`endif

   // Partial sum keeps the carry in bit N so nothing is lost on the shift.
   always_comb begin
      sum_c = {1'b0, acc_q} + (sr_q[0] ? {1'b0, mc_q} : '0);
   end

   // Next-state, datapath updates and shift register controls.
   always_comb begin
      state_d   = state_q;
      mc_d      = mc_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
`ifdef MULT_SIGNED_EN
      neg_d     = neg_q;
`endif
      sr_load   = 1'b1;
      sr_value  = mplier_op_c;
      sr_in     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               mc_d    = mcand_op_c;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef MULT_SIGNED_EN
               neg_d   = mcand[N-1] ^ mplier[N-1];
`endif
               state_d = RUN;
            end
         end
         RUN: begin
            sr_load = 1'b0;
            sr_in   = sum_c[0];
            acc_d   = sum_c[N:1];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            product_d = result_c;
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (r) begin
         state_q   <= IDLE;
         mc_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
         neg_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         mc_q      <= mc_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
`ifdef MULT_SIGNED_EN
         neg_q     <= neg_d;
`endif
      end
   end

   assign busy    = (state_q == RUN) || (state_q == DONE);
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl_16b.sv
// Directed bench for shift_add_mult_ctrl_16b, with a behavioural model of
// the neighbouring 16-bit shift register. Build with +define+MULT_SIGNED_EN
// to exercise the signed variant.
module tb_shift_add_mult_ctrl_16b;

   logic        clk = 1'b0;
   logic        r;
   logic        start;
   logic [15:0] mcand;
   logic [15:0] mplier;
   logic        busy;
   logic        done;
   logic [31:0] product;
   logic [15:0] sr_value;
   logic        sr_load;
   logic        sr_in;
   logic [15:0] sr_q;

   int total = 0;
   int bad   = 0;

   shift_add_mult_ctrl_16b #(.N(16)) dut (
      .clk      (clk),
      .r        (r),
      .start    (start),
      .mcand    (mcand),
      .mplier   (mplier),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .sr_value (sr_value),
      .sr_load  (sr_load),
      .sr_in    (sr_in),
      .sr_q     (sr_q)
   );

   always #5 clk = ~clk;

   // Neighbouring shift register: parallel load or shift right with MSB serial input.
   always @(posedge clk) begin
      if (sr_load) sr_q <= sr_value;
      else         sr_q <= {sr_in, sr_q[15:1]};
   end

   task automatic launch(input logic [15:0] a, input logic [15:0] b);
      mcand  = a;
      mplier = b;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   // Waits for done; 'already' is the number of edges consumed since acceptance.
   task automatic wait_done(input logic [31:0] exp, input int already, input string name);
      int n;
      bit seen;
      n    = already;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen || n != 17) begin
         bad++;
         $display("FAIL %s latency: got %0d edges (seen=%0d), want 17", name, n, seen);
      end
      total++;
      if (product !== exp) begin
         bad++;
         $display("FAIL %s product: got %h, want %h", name, product, exp);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL %s busy in done cycle: got %b, want 0", name, busy);
      end
   endtask

   task automatic test_reset();
      r      = 1'b1;
      start  = 1'b0;
      mcand  = 16'h0000;
      mplier = 16'h5A5A;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b, want 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b, want 0", done); end
      total++;
      if (product !== 32'h0) begin bad++; $display("FAIL reset product: got %h, want 0", product); end
      total++;
      if (sr_load !== 1'b1 || sr_in !== 1'b0) begin
         bad++; $display("FAIL reset sr ctl: got load=%b in=%b, want 1 0", sr_load, sr_in);
      end
      total++;
      if (sr_value !== 16'h5A5A) begin bad++; $display("FAIL reset sr_value: got %h, want 5a5a", sr_value); end
      r      = 1'b0;
      mplier = 16'h0F0F;
      @(posedge clk); #1;
      total++;
      if (sr_q !== 16'h0F0F || sr_value !== 16'h0F0F) begin
         bad++; $display("FAIL idle tracking: got sr_q=%h sr_value=%h, want 0f0f", sr_q, sr_value);
      end
   endtask

   task automatic test_basic();
      launch(16'd3, 16'd5);
      total++;
      if (busy !== 1'b1 || sr_load !== 1'b0) begin
         bad++; $display("FAIL basic run: got busy=%b sr_load=%b, want 1 0", busy, sr_load);
      end
      wait_done(32'h0000000F, 0, "basic");
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== 32'h0000000F) begin
         bad++; $display("FAIL basic after: got done=%b busy=%b product=%h, want 0 0 0000000f", done, busy, product);
      end
   endtask

   task automatic test_max();
`ifdef MULT_SIGNED_EN
      launch(16'hFFFF, 16'hFFFF);
      wait_done(32'h00000001, 0, "max");
`else
      launch(16'hFFFF, 16'hFFFF);
      wait_done(32'hFFFE0001, 0, "max");
`endif
   endtask

   task automatic test_back_to_back();
      launch(16'h0000, 16'h1234);
      wait_done(32'h00000000, 0, "zero");
      launch(16'h8000, 16'h0002);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL b2b accept: got busy=%b, want 1", busy); end
`ifdef MULT_SIGNED_EN
      wait_done(32'hFFFF0000, 0, "b2b");
`else
      wait_done(32'h00010000, 0, "b2b");
`endif
   endtask

   task automatic test_abort();
      int pulses;
      launch(16'hABCD, 16'h0101);
      repeat (7) @(posedge clk);
      #1;
      r = 1'b1;
      @(posedge clk); #1;
      r = 1'b0;
      total++;
      if (busy !== 1'b0 || product !== 32'h0 || done !== 1'b0) begin
         bad++; $display("FAIL abort state: got busy=%b product=%h done=%b, want 0 0 0", busy, product, done);
      end
      pulses = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done === 1'b1) pulses++;
      end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL abort done pulses: got %0d, want 0", pulses); end
      launch(16'd7, 16'd9);
      wait_done(32'h0000003F, 0, "after abort");
   endtask

   task automatic test_start_busy();
      launch(16'h1111, 16'h0003);
      repeat (4) @(posedge clk);
      #1;
      mcand  = 16'hFFFF;
      mplier = 16'hFFFF;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      wait_done(32'h00003333, 5, "start busy");
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL start busy queued: got busy=%b, want 0", busy); end
   endtask

`ifdef MULT_SIGNED_EN
   task automatic test_signed();
      launch(16'hFFFD, 16'd5);
      wait_done(32'hFFFFFFF1, 0, "signed neg");
      launch(16'h8000, 16'h8000);
      wait_done(32'h40000000, 0, "signed minmin");
      launch(16'hFFFF, 16'h0000);
      wait_done(32'h00000000, 0, "signed zero");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_max();
      test_back_to_back();
      test_abort();
      test_start_busy();
`ifdef MULT_SIGNED_EN
      test_signed();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_add_mult_ctrl_16b.md
# shift_add_mult_ctrl_16b

- Sequencing and accumulation stage of the 16-bit shift-add integer multiplier.
- Drives the neighbouring 16-bit shift register, which holds the multiplier and, as iterations proceed, the low product bits:
  - `sr_value` / `sr_load` / `sr_in` go to the shift register.
  - The shift register's `Q` returns as `sr_q`.
- Owns the multiplicand register, the 16-bit accumulator (high product half), the iteration counter and the start/busy/done handshake.
- Presents a registered 32-bit product.

## Interface
Parameters:
- `N`, default 16: operand width. Only 16 is supported; the counter and product width derive from it.

Ports:
- `clk` in, 1: clock. Rising edge is active.
- `r` in, 1: reset. Synchronous and active-high.
- `start` in, 1: request a multiply. Sampled only in IDLE.
- `mcand` in, 16: multiplicand. Sampled on the edge that accepts `start`.
- `mplier` in, 16: multiplier. Loaded into the shift register on the edge that accepts `start`.
- `busy` out, 1: high while the state is RUN or DONE.
- `done` out, 1: registered, one-cycle pulse. Indicates that `product` has just been updated.
- `product` out, 32: last completed result. Held until the next completion.
- `sr_value` out, 16: parallel load value for the shift register.
- `sr_load` out, 1: shift register load select. 1 = parallel load, 0 = shift right.
- `sr_in` out, 1: serial input of the shift register, entering at the MSB.
- `sr_q` in, 16: shift register contents.

## Operation
States are IDLE, RUN and DONE.

IDLE:
- `sr_load`=1 and `sr_value`=`mplier`, so the shift register tracks `mplier` every edge.
- When `start`=1: `mc`<=`mcand`, `acc`<=0, `cnt`<=0, state<=RUN.

RUN:
- `sr_load`=0.
- Combinational `sum[16:0]` = `acc` + (`sr_q[0]` ? `mc` : 0).
- `sr_in` = `sum[0]`.
- On each edge:
  - `acc`<=`sum[16:1]`.
  - The shift register shifts right, taking in `sr_in`.
  - `cnt`<=`cnt`+1.
- After the edge where `cnt`=15, state<=DONE. RUN lasts exactly 16 cycles.

DONE:
- `sr_load`=1 and `sr_value`=`mplier`, which freezes the low half against further shifting.
- On the edge: `product`<={`acc`, `sr_q`}, `done`<=1, state<=IDLE.

Other rules:
- `done`<=0 on every edge not leaving DONE.
- `start` during RUN or DONE is ignored. It is not queued.
- Arithmetic:
  - `sum` is 17 bits, so the carry is never lost.
  - In unsigned mode the product is exact for all operand pairs.
- Reset (`r`=1 on an edge), from any state and mid-operation included:
  - state<=IDLE.
  - `acc`, `mc`, `cnt`, `product` <= 0.
  - `done`<=0.
  - The in-flight operation is discarded; no `done` is produced for it.

Reset values:
- `busy`=0, `done`=0, `product`=0.
- `sr_load`=1, `sr_in`=0.
- `sr_value`=`mplier`.

## Timing
- Latency from `start` to `done`: `start` is accepted at edge E0, RUN spans edges E1..E16, DONE captures at E17, and `done` is high in the cycle after E17. Latency is therefore 17 clock edges.
- `busy` is high from after E0 through the cycle ending at E17.
- Throughput is one multiply per 18 cycles. A `start` held high in the `done` cycle is accepted immediately.
- `product` changes only at the DONE edge or at reset.
- `sr_in` and `sr_load` are combinational from state, `acc` and `sr_q`. They must settle within one cycle.

## Configuration
`MULT_SIGNED_EN`.

Defined (two's-complement operands):
- At acceptance:
  - `neg`<=`mcand[15]`^`mplier[15]`.
  - `mc`<=|`mcand`|.
  - `sr_value`=|`mplier|` in IDLE.
  - 0x8000 maps to magnitude 0x8000.
- At DONE: `product`<= `neg` ? −{`acc`,`sr_q`} : {`acc`,`sr_q`}, negated in 32 bits.
- A zero result stays 0.
- Latency is unchanged.

Undefined:
- Operands are unsigned.
- No `neg` register and no negation logic exist.

## Test plan
- Basic multiply: reset 2 cycles, then `start` with `mcand`=3, `mplier`=5 → `done` 17 edges after acceptance, `product`=0x0000000F, `busy` low the following cycle.
- Maximum operands: 0xFFFF × 0xFFFF → `product`=0xFFFE0001. Checks carry through `sum[16]`.
- Zero operand, then back-to-back: 0 × 0x1234 → 0. Then `start` held high in the `done` cycle with 0x8000 × 2 → 0x00010000, no idle gap.
- Abort by reset: `start` 0xABCD × 0x0101, assert `r` at RUN cycle 8 → `busy`=0, `product`=0, no `done`. Then a new 7 × 9 → 0x3F.
- Start while busy: `start` pulse at RUN cycle 5 with different operands → ignored, and the original result is delivered unchanged.
- Signed (`MULT_SIGNED_EN` defined): −3 (0xFFFD) × 5 → 0xFFFFFFF1. Then 0x8000 × 0x8000 → 0x40000000. Then −1 × 0 → 0.
